// File: rtl/segre_mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   WORD_SIZE, CACHE_LINE_SIZE_BYTES : datapath widths
//   memop_data_type_e                : access size (BYTE/HALF/WORD)
//   arb_state_e / arb_owner_e        : arbiter FSM state and bus owner
package segre_mem_arbiter_pkg;

   localparam int WORD_SIZE             = 32;
   localparam int CACHE_LINE_SIZE_BYTES = 16;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } memop_data_type_e;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'b00,
      ARB_SERVE_IF  = 2'b01,
      ARB_SERVE_MEM = 2'b10
   } arb_state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } arb_owner_e;

   // Width of a counter that must hold 0..limit inclusive.
   function automatic int starve_cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/segre_mem_arbiter_if.sv
// Bundle of the three handshakes around the arbiter: the IF requester,
// the MEM requester and the downstream memory port.
//   slave  : arbiter view (requests/ack in, grants/valids/downstream out)
//   master : environment view (requesters and memory model)
interface segre_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_BYTES = segre_mem_arbiter_pkg::CACHE_LINE_SIZE_BYTES
) ();
   import segre_mem_arbiter_pkg::*;

   logic                    if_req_i;
   logic [ADDR_WIDTH-1:0]   if_addr_i;
   logic                    if_gnt_o;
   logic                    if_valid_o;
   logic [LINE_BYTES*8-1:0] if_data_o;

   logic                    mem_req_i;
   logic                    mem_wr_i;
   logic [ADDR_WIDTH-1:0]   mem_addr_i;
   logic [WORD_SIZE-1:0]    mem_wdata_i;
   memop_data_type_e        mem_type_i;
   logic                    mem_gnt_o;
   logic                    mem_valid_o;
   logic [LINE_BYTES*8-1:0] mem_data_o;

   logic                    m_req_o;
   logic                    m_wr_o;
   logic [ADDR_WIDTH-1:0]   m_addr_o;
   logic [WORD_SIZE-1:0]    m_wdata_o;
   memop_data_type_e        m_type_o;
   logic                    m_ack_i;
   logic [LINE_BYTES*8-1:0] m_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_valid_o, if_data_o,
      input  mem_req_i, mem_wr_i, mem_addr_i, mem_wdata_i, mem_type_i,
      output mem_gnt_o, mem_valid_o, mem_data_o,
      output m_req_o, m_wr_o, m_addr_o, m_wdata_o, m_type_o,
      input  m_ack_i, m_rdata_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_valid_o, if_data_o,
      output mem_req_i, mem_wr_i, mem_addr_i, mem_wdata_i, mem_type_i,
      input  mem_gnt_o, mem_valid_o, mem_data_o,
      input  m_req_o, m_wr_o, m_addr_o, m_wdata_o, m_type_o,
      output m_ack_i, m_rdata_i
   );

endinterface

// File: rtl/segre_mem_arbiter_pick.sv
// Combinational winner selection for the memory-port arbiter.
//   i_if_req / i_mem_req : pending requests
//   i_starve_cnt         : consecutive MEM grants while IF waited
//   i_last_owner         : owner of the previous transaction
//   o_any_req            : at least one request pending
//   o_winner             : requester to grant (meaningful with o_any_req)
// Build option: SEGRE_MEM_ARB_RR_EN selects round-robin on collisions;
// otherwise MEM has fixed priority with an IF starvation guard.
module segre_mem_arb_pick
   import segre_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = starve_cnt_width(STARVE_LIMIT)
) (
   input  logic             i_if_req,
   input  logic             i_mem_req,
   input  logic [CNT_W-1:0] i_starve_cnt,
   input  arb_owner_e       i_last_owner,
   output logic             o_any_req,
   output arb_owner_e       o_winner
);

   assign o_any_req = i_if_req | i_mem_req;

`ifdef SEGRE_MEM_ARB_RR_EN
   logic w_unused_cnt;
   assign w_unused_cnt = ^i_starve_cnt;

   always_comb begin
      o_winner = OWN_IF;
      if (i_if_req && i_mem_req) begin
         // whoever did not own the port last time goes next
         o_winner = (i_last_owner == OWN_IF) ? OWN_MEM : OWN_IF;
      end else if (i_mem_req) begin
         o_winner = OWN_MEM;
      end
   end
`else
   logic w_unused_owner;
   assign w_unused_owner = i_last_owner;

   always_comb begin
      o_winner = OWN_IF;
      // MEM wins unless IF is waiting and has already been passed over too often
      if (i_mem_req && !(i_if_req && (i_starve_cnt == CNT_W'(STARVE_LIMIT)))) begin
         o_winner = OWN_MEM;
      end
   end
`endif

endmodule

// File: rtl/segre_mem_arbiter.sv
// Shares the single memory port between instruction fetch (line reads) and
// the MEM stage (loads/stores). One transaction at a time; the grant is
// combinational in IDLE, the downstream request and the valid pulses are
// registered.
//   clk_i, rst_i : clock (rising edge), asynchronous active-high reset
//   bus          : IF / MEM / downstream handshakes (slave modport)
// Build option: SEGRE_MEM_ARB_RR_EN -> round-robin on simultaneous requests,
// starve counter held at 0.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ARB_IDLE      | port free; grant the winner in the same cycle
// ARB_SERVE_IF  | IF line read outstanding, m_req_o held until m_ack_i
// ARB_SERVE_MEM | MEM load/store outstanding, m_req_o held until m_ack_i
module segre_mem_arbiter
   import segre_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int LINE_BYTES   = CACHE_LINE_SIZE_BYTES,
   parameter int STARVE_LIMIT = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   segre_mem_arbiter_if.slave bus
);

   localparam int CNT_W = starve_cnt_width(STARVE_LIMIT);

   arb_state_e              r_state;
   arb_owner_e              r_last_owner;
   logic [CNT_W-1:0]        r_starve_cnt;

   logic                    r_m_req;
   logic                    r_m_wr;
   logic [ADDR_WIDTH-1:0]   r_m_addr;
   logic [WORD_SIZE-1:0]    r_m_wdata;
   memop_data_type_e        r_m_type;

   logic                    r_if_valid;
   logic                    r_mem_valid;
   logic [LINE_BYTES*8-1:0] r_if_data;
   logic [LINE_BYTES*8-1:0] r_mem_data;

   logic                    w_any_req;
   arb_owner_e              w_winner;
   logic                    w_grant;
   logic                    w_if_gnt;
   logic                    w_mem_gnt;

   segre_mem_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_pick (
      .i_if_req     (bus.if_req_i),
      .i_mem_req    (bus.mem_req_i),
      .i_starve_cnt (r_starve_cnt),
      .i_last_owner (r_last_owner),
      .o_any_req    (w_any_req),
      .o_winner     (w_winner)
   );

   // grants are combinational; held low while reset is asserted
   assign w_grant   = (r_state == ARB_IDLE) && w_any_req && !rst_i;
   assign w_if_gnt  = w_grant && (w_winner == OWN_IF);
   assign w_mem_gnt = w_grant && (w_winner == OWN_MEM);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ARB_IDLE;
         r_last_owner <= OWN_IF;
         r_starve_cnt <= '0;
         r_m_req      <= 1'b0;
         r_m_wr       <= 1'b0;
         r_m_addr     <= '0;
         r_m_wdata    <= '0;
         r_m_type     <= BYTE;
         r_if_valid   <= 1'b0;
         r_mem_valid  <= 1'b0;
         r_if_data    <= '0;
         r_mem_data   <= '0;
      end else begin
         r_if_valid  <= 1'b0;
         r_mem_valid <= 1'b0;
         case (r_state)
            ARB_IDLE: begin
               // m_ack_i here is spurious and deliberately ignored
               if (w_grant) begin
                  r_m_req      <= 1'b1;
                  r_last_owner <= w_winner;
                  if (w_winner == OWN_IF) begin
                     r_state      <= ARB_SERVE_IF;
                     r_m_wr       <= 1'b0;
                     r_m_addr     <= bus.if_addr_i;
                     r_m_wdata    <= '0;
                     r_m_type     <= WORD;
                     r_starve_cnt <= '0;
                  end else begin
                     r_state   <= ARB_SERVE_MEM;
                     r_m_wr    <= bus.mem_wr_i;
                     r_m_addr  <= bus.mem_addr_i;
                     r_m_wdata <= bus.mem_wdata_i;
                     r_m_type  <= bus.mem_type_i;
`ifndef SEGRE_MEM_ARB_RR_EN
                     if (bus.if_req_i && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                     end
`endif
                  end
               end
            end
            ARB_SERVE_IF: begin
               if (bus.m_ack_i) begin
                  r_m_req    <= 1'b0;
                  r_state    <= ARB_IDLE;
                  r_if_valid <= 1'b1;
                  r_if_data  <= bus.m_rdata_i;
               end
            end
            ARB_SERVE_MEM: begin
               if (bus.m_ack_i) begin
                  r_m_req     <= 1'b0;
                  r_state     <= ARB_IDLE;
                  r_mem_valid <= 1'b1;
                  // for stores this is don't-care data; capturing it keeps the path uniform
                  r_mem_data  <= bus.m_rdata_i;
               end
            end
            default: begin
               r_state <= ARB_IDLE;
               r_m_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus.if_gnt_o    = w_if_gnt;
   assign bus.if_valid_o  = r_if_valid;
   assign bus.if_data_o   = r_if_data;
   assign bus.mem_gnt_o   = w_mem_gnt;
   assign bus.mem_valid_o = r_mem_valid;
   assign bus.mem_data_o  = r_mem_data;
   assign bus.m_req_o     = r_m_req;
   assign bus.m_wr_o      = r_m_wr;
   assign bus.m_addr_o    = r_m_addr;
   assign bus.m_wdata_o   = r_m_wdata;
   assign bus.m_type_o    = r_m_type;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter with a queue of expected completions.
// Honours SEGRE_MEM_ARB_RR_EN for the starvation/round-robin sequence.
module tb_segre_mem_arbiter;
   import segre_mem_arbiter_pkg::*;

   localparam int LW = CACHE_LINE_SIZE_BYTES * 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   segre_mem_arbiter_if bus ();

   segre_mem_arbiter #(
      .ADDR_WIDTH   (32),
      .LINE_BYTES   (CACHE_LINE_SIZE_BYTES),
      .STARVE_LIMIT (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      bit            is_if;
      bit            chk_data;
      logic [LW-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   function automatic logic [LW-1:0] line_of(input logic [31:0] a);
      return {(LW/32){a ^ 32'h5A5A_0000}};
   endfunction

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input bit is_if, input bit chk_data, input logic [31:0] addr);
      exp_t e;
      e.is_if    = is_if;
      e.chk_data = chk_data;
      e.data     = line_of(addr);
      exp_q.push_back(e);
   endtask

   // completion monitor: every valid pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (bus.if_valid_o === 1'b1 || bus.mem_valid_o === 1'b1)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", {bus.if_valid_o, bus.mem_valid_o}, 2'b00);
         end else begin
            e = exp_q.pop_front();
            check("valid_owner", {bus.if_valid_o, bus.mem_valid_o}, e.is_if ? 2'b10 : 2'b01);
            if (e.chk_data)
               check("valid_data", e.is_if ? bus.if_data_o : bus.mem_data_o, e.data);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Called at the negedge of the grant cycle; acks k cycles after the grant.
   task automatic ack_after(input int k, input logic [31:0] addr, input bit is_if, input bit wr,
                            input logic [31:0] wdata, input memop_data_type_e mtype,
                            input bit drop_if, input bit drop_mem);
      for (int j = 1; j <= k; j++) begin
         cyc();
         if (j == 1) begin
            if (drop_if)  bus.if_req_i  = 1'b0;
            if (drop_mem) bus.mem_req_i = 1'b0;
         end
         if (j == k) begin
            bus.m_ack_i   = 1'b1;
            bus.m_rdata_i = line_of(addr);
         end
         @(negedge clk);
         check("m_req_held", bus.m_req_o, 1'b1);
         if (j == 1) begin
            check("m_addr", bus.m_addr_o, addr);
            check("m_wr", bus.m_wr_o, wr);
            if (!is_if) check("m_type", bus.m_type_o, mtype);
            if (wr)     check("m_wdata", bus.m_wdata_o, wdata);
         end
      end
      cyc();
      bus.m_ack_i   = 1'b0;
      bus.m_rdata_i = '0;
      @(negedge clk);
      check("m_req_drop", bus.m_req_o, 1'b0);
      check("valid_pulse", {bus.if_valid_o, bus.mem_valid_o}, is_if ? 2'b10 : 2'b01);
   endtask

   bit exp_seq_mem [6];

   initial begin
      rst             = 1'b1;
      bus.if_req_i    = 1'b1;
      bus.if_addr_i   = 32'h0;
      bus.mem_req_i   = 1'b1;
      bus.mem_wr_i    = 1'b0;
      bus.mem_addr_i  = 32'h0;
      bus.mem_wdata_i = 32'h0;
      bus.mem_type_i  = WORD;
      bus.m_ack_i     = 1'b0;
      bus.m_rdata_i   = '0;

      // reset: outputs quiet even with requests pending
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnts", {bus.if_gnt_o, bus.mem_gnt_o}, 2'b00);
      check("rst_m_req", bus.m_req_o, 1'b0);
      check("rst_valids", {bus.if_valid_o, bus.mem_valid_o}, 2'b00);
      check("rst_if_data", bus.if_data_o, '0);
      check("rst_m_addr", bus.m_addr_o, 32'h0);
      cyc();
      rst           = 1'b0;
      bus.if_req_i  = 1'b0;
      bus.mem_req_i = 1'b0;

      // 1: IF-only read, ack 3 cycles after grant
      cyc();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h100;
      push_exp(1'b1, 1'b1, 32'h100);
      @(negedge clk);
      check("t1_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 2'b10);
      ack_after(3, 32'h100, 1'b1, 1'b0, 32'h0, WORD, 1'b1, 1'b0);

      // 2: simultaneous IF + MEM load, MEM first
      cyc();
      bus.if_req_i   = 1'b1;
      bus.if_addr_i  = 32'h200;
      bus.mem_req_i  = 1'b1;
      bus.mem_wr_i   = 1'b0;
      bus.mem_addr_i = 32'h300;
      bus.mem_type_i = WORD;
      push_exp(1'b0, 1'b1, 32'h300);
      push_exp(1'b1, 1'b1, 32'h200);
      @(negedge clk);
      check("t2_gnt_mem", {bus.if_gnt_o, bus.mem_gnt_o}, 2'b01);
      ack_after(2, 32'h300, 1'b0, 1'b0, 32'h0, WORD, 1'b0, 1'b1);
      check("t2_gnt_if", {bus.if_gnt_o, bus.mem_gnt_o}, 2'b10);
      ack_after(1, 32'h200, 1'b1, 1'b0, 32'h0, WORD, 1'b1, 1'b0);

      // 3: both requesters held, grant pattern over six transactions
`ifdef SEGRE_MEM_ARB_RR_EN
      exp_seq_mem = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_seq_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
      cyc();
      bus.if_req_i   = 1'b1;
      bus.if_addr_i  = 32'h500;
      bus.mem_req_i  = 1'b1;
      bus.mem_wr_i   = 1'b0;
      bus.mem_addr_i = 32'h600;
      bus.mem_type_i = HALF;
      @(negedge clk);
      for (int g = 0; g < 6; g++) begin
         check($sformatf("t3_gnt%0d", g), {bus.if_gnt_o, bus.mem_gnt_o},
               exp_seq_mem[g] ? 2'b01 : 2'b10);
         if (exp_seq_mem[g]) begin
            push_exp(1'b0, 1'b1, 32'h600);
            ack_after(1, 32'h600, 1'b0, 1'b0, 32'h0, HALF, g == 5, g == 5);
         end else begin
            push_exp(1'b1, 1'b1, 32'h500);
            ack_after(1, 32'h500, 1'b1, 1'b0, 32'h0, WORD, g == 5, g == 5);
         end
      end

      // 4: WORD store
      cyc();
      bus.mem_req_i   = 1'b1;
      bus.mem_wr_i    = 1'b1;
      bus.mem_addr_i  = 32'h40;
      bus.mem_wdata_i = 32'hDEAD_BEEF;
      bus.mem_type_i  = WORD;
      push_exp(1'b0, 1'b0, 32'h40);
      @(negedge clk);
      check("t4_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 2'b01);
      ack_after(2, 32'h40, 1'b0, 1'b1, 32'hDEAD_BEEF, WORD, 1'b0, 1'b1);

      // 5: reset in the middle of a MEM load
      cyc();
      bus.mem_req_i   = 1'b1;
      bus.mem_wr_i    = 1'b0;
      bus.mem_addr_i  = 32'h700;
      bus.mem_type_i  = BYTE;
      @(negedge clk);
      check("t5_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 2'b01);
      cyc();
      bus.mem_req_i = 1'b0;
      @(negedge clk);
      check("t5_m_req_pre", bus.m_req_o, 1'b1);
      cyc();
      rst = 1'b1;
      @(negedge clk);
      check("t5_m_req_rst", bus.m_req_o, 1'b0);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         bus.m_ack_i   = (i == 0);
         bus.m_rdata_i = line_of(32'h700);
         @(negedge clk);
         check("t5_quiet", {bus.m_req_o, bus.if_valid_o, bus.mem_valid_o}, 3'b000);
      end
      cyc();
      bus.m_ack_i   = 1'b0;
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h180;
      push_exp(1'b1, 1'b1, 32'h180);
      @(negedge clk);
      check("t5_fresh_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 2'b10);
      ack_after(1, 32'h180, 1'b1, 1'b0, 32'h0, WORD, 1'b1, 1'b0);

      // 6: spurious ack in IDLE, then IF drops its request right after grant
      cyc();
      bus.m_ack_i   = 1'b1;
      bus.m_rdata_i = line_of(32'hBAD0);
      @(negedge clk);
      check("t6_spur_req", {bus.m_req_o, bus.if_gnt_o, bus.mem_gnt_o}, 3'b000);
      cyc();
      bus.m_ack_i   = 1'b0;
      bus.m_rdata_i = '0;
      @(negedge clk);
      check("t6_spur_valid", {bus.m_req_o, bus.if_valid_o, bus.mem_valid_o}, 3'b000);
      cyc();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h900;
      push_exp(1'b1, 1'b1, 32'h900);
      @(negedge clk);
      check("t6_gnt", {bus.if_gnt_o, bus.mem_gnt_o}, 2'b10);
      ack_after(2, 32'h900, 1'b1, 1'b0, 32'h0, WORD, 1'b1, 1'b0);

      repeat (3) cyc();
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
